// File: rtl/demux8to16_packer_pkg.sv
// Shared types and defaults for the byte-to-halfword packer.
package demux8to16_packer_pkg;

    localparam int unsigned BYTE_W = 8;

    // 2'b11 is unused and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/demux8to16_packer_if.sv
// Byte-in / word-out handshake bundle for the packer.
interface demux8to16_packer_if
    import demux8to16_packer_pkg::*;
#(
    parameter int unsigned W = BYTE_W
) ();

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         clear;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         out_valid;
    logic         out_ready;
    logic         slot;

    // Environment side: produces bytes, consumes words.
    modport master (
        output in_data, in_valid, clear, out_ready,
        input  in_ready, out_a, out_b, out_valid, slot
    );

    // Packer side.
    modport slave (
        input  in_data, in_valid, clear, out_ready,
        output in_ready, out_a, out_b, out_valid, slot
    );

endinterface

// File: rtl/demux8to16_packer_reg_en.sv
// W-bit register with synchronous active-low reset and load enable.
module demux8to16_packer_reg_en #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/demux8to16_packer.sv
// Packs alternate bytes of a valid/ready stream into {b,a} words.
module demux8to16_packer
    import demux8to16_packer_pkg::*;
#(
    parameter int unsigned W = BYTE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    demux8to16_packer_if.slave  bus
);

    state_t state_q;
    state_t state_d;
    logic   load_a;
    logic   load_b;
    logic   in_xfer;

    // in_ready follows out_ready in FULL so a word boundary costs no bubble.
    always_comb begin
        bus.in_ready = 1'b0;
        case (state_q)
            EMPTY:   bus.in_ready = 1'b1;
            HALF:    bus.in_ready = 1'b1;
            FULL:    bus.in_ready = bus.out_ready;
            default: bus.in_ready = 1'b0;
        endcase
        if (bus.clear) begin
            bus.in_ready = 1'b0;
        end
    end

    assign in_xfer = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_a  = 1'b1;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (in_xfer) begin
                    load_b  = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    if (in_xfer) begin
                        load_a  = 1'b1;
                        state_d = HALF;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        // clear wins over any handshake; in_ready is already low here.
        if (bus.clear) begin
            load_a  = 1'b0;
            load_b  = 1'b0;
            state_d = EMPTY;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.slot      = (state_q == HALF);

    demux8to16_packer_reg_en #(.W(W)) u_reg_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_a),
        .d     (bus.in_data),
        .q     (bus.out_a)
    );

    demux8to16_packer_reg_en #(.W(W)) u_reg_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_b),
        .d     (bus.in_data),
        .q     (bus.out_b)
    );

endmodule

// File: tb/tb_demux8to16_packer.sv
// Directed bench for demux8to16_packer with hand-computed expectations.
module tb_demux8to16_packer;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    demux8to16_packer_if #(.W(8)) bus ();

    demux8to16_packer #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [15:0] exp);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_word"}, 32'({bus.out_b, bus.out_a}), 32'(exp));
    endtask

    initial begin
        tests         = 0;
        failed        = 0;
        rst_n         = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_out_a", 32'(bus.out_a), 32'h0);
        chk("rst_out_b", 32'(bus.out_b), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_slot", 32'(bus.slot), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Test 1: two bytes -> one word
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h12;
        #1;
        chk("t1_slot0", 32'(bus.slot), 32'd0);
        tick();
        chk("t1_slot1", 32'(bus.slot), 32'd1);
        chk("t1_half_a", 32'(bus.out_a), 32'h12);
        chk("t1_half_b", 32'(bus.out_b), 32'h00);
        chk("t1_half_valid", 32'(bus.out_valid), 32'd0);
        bus.in_data = 8'h34;
        tick();
        chk_word("t1", 16'h3412);
        chk("t1_slot2", 32'(bus.slot), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        chk("t1_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_hold_a", 32'(bus.out_a), 32'h12);

        // Test 2: back-to-back stream, no bubble
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.in_data = 8'(i);
            #1;
            chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            if (i % 2 == 0) begin
                chk_word("t2", {8'(i), 8'(i - 1)});
            end else begin
                chk("t2_odd_valid", 32'(bus.out_valid), 32'd0);
                chk("t2_odd_a", 32'(bus.out_a), 32'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t2_drain_valid", 32'(bus.out_valid), 32'd0);

        // Test 3: backpressure holds word and blocks input
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAA;
        tick();
        bus.in_data = 8'hBB;
        tick();
        bus.in_data = 8'hCC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
            tick();
            chk_word("t3_hold", 16'hBBAA);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t3_in_ready_high", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t3_valid", 32'(bus.out_valid), 32'd0);
        chk("t3_slot", 32'(bus.slot), 32'd1);
        chk("t3_a", 32'(bus.out_a), 32'hCC);
        chk("t3_b", 32'(bus.out_b), 32'hBB);

        // Test 4: clear in HALF discards the partial word
        bus.in_valid = 1'b0;
        bus.clear    = 1'b1;
        tick();
        chk("t4_pre_slot", 32'(bus.slot), 32'd0);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        tick();
        chk("t4_half_a", 32'(bus.out_a), 32'h55);
        bus.clear   = 1'b1;
        bus.in_data = 8'h99;
        #1;
        chk("t4_clear_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t4_slot", 32'(bus.slot), 32'd0);
        chk("t4_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_a_kept", 32'(bus.out_a), 32'h55);
        bus.clear   = 1'b0;
        bus.in_data = 8'h66;
        tick();
        bus.in_data = 8'h77;
        tick();
        chk_word("t4", 16'h7766);

        // Test 5: clear in FULL discards word and drops byte
        bus.clear   = 1'b1;
        bus.in_data = 8'h88;
        #1;
        chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_slot", 32'(bus.slot), 32'd0);
        chk("t5_word_kept", 32'({bus.out_b, bus.out_a}), 32'h7766);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("t5_idle_valid", 32'(bus.out_valid), 32'd0);

        // Test 6: reset in HALF and in FULL
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        tick();
        chk("t6_half_slot", 32'(bus.slot), 32'd1);
        rst_n       = 1'b0;
        bus.in_data = 8'h22;
        tick();
        chk("t6_rh_a", 32'(bus.out_a), 32'h0);
        chk("t6_rh_b", 32'(bus.out_b), 32'h0);
        chk("t6_rh_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rh_slot", 32'(bus.slot), 32'd0);
        rst_n       = 1'b1;
        bus.in_data = 8'h33;
        tick();
        chk("t6_load_a", 32'(bus.out_a), 32'h33);
        chk("t6_load_slot", 32'(bus.slot), 32'd1);
        bus.out_ready = 1'b0;
        bus.in_data   = 8'h44;
        tick();
        chk_word("t6_full", 16'h4433);
        rst_n = 1'b0;
        tick();
        chk("t6_rf_a", 32'(bus.out_a), 32'h0);
        chk("t6_rf_b", 32'(bus.out_b), 32'h0);
        chk("t6_rf_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rf_slot", 32'(bus.slot), 32'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data   = 8'h5A;
        tick();
        chk("t6_after_a", 32'(bus.out_a), 32'h5A);
        chk("t6_after_b", 32'(bus.out_b), 32'h0);
        chk("t6_after_slot", 32'(bus.slot), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/demux8to16_packer.md
Name: demux8to16_packer

Overview:
- Reverse direction of the team's 16-to-8 byte-select mux.
- Accepts a stream of W-bit bytes on one valid/ready input and steers alternate bytes into an "a" (low) slot and a "b" (high) slot.
- Presents the completed {b,a} pair as one 2W-bit word on a valid/ready output.
- Sits between a byte-wide source and 16-bit datapath consumers.

Parameters:
W, 8, byte width; output word is 2W bits.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset; synchronous, active-low.
in_data  input  W  incoming byte.
in_valid  input  1  in_data valid this cycle.
in_ready  output  1  block accepts in_data this cycle.
clear  input  1  synchronous flush of any partial or full word.
out_a  output  W  low byte of word (first byte received).
out_b  output  W  high byte of word (second byte received).
out_valid  output  1  {out_b,out_a} holds a complete word.
out_ready  input  1  consumer accepts word this cycle.
slot  output  1  slot for the next accepted byte: 0 = a, 1 = b.

Behaviour:
- Reset (rst_n=0 at an edge): state=EMPTY, out_a=0, out_b=0, out_valid=0, slot=0. Reset overrides clear and all handshakes, including mid-word.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- States: EMPTY (no bytes), HALF (a loaded), FULL (a and b loaded).
- EMPTY:
  - in_ready=1.
  - On input transfer: out_a<=in_data, go to HALF, slot<=1.
- HALF:
  - in_ready=1.
  - On input transfer: out_b<=in_data, go to FULL, slot<=0, out_valid<=1.
- FULL:
  - out_valid=1 and in_ready=out_ready. This is a combinational path, by design.
  - On output transfer with no input transfer: go to EMPTY, out_valid<=0.
  - On output transfer with a simultaneous input transfer: out_a<=in_data, go to HALF, out_valid<=0, slot<=1.
  - With out_ready=0: hold everything and do not accept input.
- Latency: the word is valid in the cycle after the edge that accepts the second byte.
- Throughput: 1 byte/cycle sustained while out_ready=1. No bubble at word boundaries.
- out_a and out_b change only when loaded. After transfer or clear they hold their last value; they are not zeroed.
- clear (rst_n=1):
  - Forces in_ready=0 in that cycle; any offered byte is dropped.
  - Next state is EMPTY, out_valid<=0, slot<=0.
  - A FULL word is discarded even if out_ready=1 that cycle. Consumers must ignore out_valid in a clear cycle.
- in_valid=0 in HALF: wait indefinitely; the partial word is retained.
- out_valid never deasserts without an output transfer, clear, or reset.
- slot always equals (state==HALF).

Decomposition:
- Shared package/include: state encodings EMPTY=2'b00, HALF=2'b01, FULL=2'b10 (2'b11 illegal, recovers to EMPTY), and default byte width 8.
- One natural sub-module: reg_en (W-bit register with synchronous active-low reset and load enable), instantiated twice for out_a and out_b.
- FSM and handshake logic stay in the top module.

Test Plan:
1. Reset then bytes 8'h12, 8'h34 on consecutive cycles, out_ready=1 -> out_valid high one cycle with out_b=8'h34, out_a=8'h12; slot sequence 0,1,0; out_a/out_b=0 before the first load.
2. Back-to-back stream 8'h01..8'h06 with in_valid=1, out_ready=1 -> words {02,01},{04,03},{06,05} on alternate cycles; in_ready stays 1 throughout.
3. Backpressure: fill with 8'hAA, 8'hBB, out_ready=0 for 3 cycles while offering 8'hCC -> in_ready=0, word held stable; on out_ready=1, 8'hCC is accepted the same cycle and the next state is HALF with out_a=8'hCC.
4. clear in HALF after 8'h55 -> EMPTY and slot=0; next bytes 8'h66, 8'h77 produce word {77,66}, not {66,55}.
5. clear in FULL with out_ready=1 and in_valid=1 -> word discarded, byte dropped (in_ready=0), out_valid=0 next cycle, out_a/out_b retain their old values.
6. rst_n=0 asserted in HALF and in FULL -> next cycle all outputs are 0, slot=0, and the next byte is loaded into out_a.
